// File: rtl/pipeline_hazard_controller_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The master side is the datapath (reports ID/EX/MEM status, consumes enables
// and flushes); the slave side is pipeline_hazard_controller.
interface pipeline_hazard_controller_if;
    logic [4:0]  id_registerRsAddress;
    logic [4:0]  id_registerRtAddress;
    logic        id_usesRs;
    logic        id_usesRt;
    logic        ex_isLoad;
    logic [4:0]  ex_registerWriteAddress;
    logic        mem_shouldRedirect;
    logic        mem_memoryRequest;
    logic        mem_memoryReady;
    logic        pcEnable;
    logic        ifIdEnable;
    logic        idExEnable;
    logic        exMemEnable;
    logic        memWbEnable;
    logic        pcSelectRedirect;
    logic        ifIdFlush;
    logic        idExFlush;
    logic        exMemFlush;
    logic        memTimeoutError;
    logic [31:0] stallCycleCount;
    logic [31:0] redirectCount;

    modport master (
        output id_registerRsAddress, id_registerRtAddress, id_usesRs, id_usesRt,
               ex_isLoad, ex_registerWriteAddress, mem_shouldRedirect,
               mem_memoryRequest, mem_memoryReady,
        input  pcEnable, ifIdEnable, idExEnable, exMemEnable, memWbEnable,
               pcSelectRedirect, ifIdFlush, idExFlush, exMemFlush,
               memTimeoutError, stallCycleCount, redirectCount
    );

    modport slave (
        input  id_registerRsAddress, id_registerRtAddress, id_usesRs, id_usesRt,
               ex_isLoad, ex_registerWriteAddress, mem_shouldRedirect,
               mem_memoryRequest, mem_memoryReady,
        output pcEnable, ifIdEnable, idExEnable, exMemEnable, memWbEnable,
               pcSelectRedirect, ifIdFlush, idExFlush, exMemFlush,
               memTimeoutError, stallCycleCount, redirectCount
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Priority each cycle: memory wait > MEM redirect > load-use hazard.
// Optional feature: define HAZARD_PERF_COUNTERS_EN to build the stall and
// redirect performance counters; otherwise both counter ports read zero.
module pipeline_hazard_controller #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int MEM_TIMEOUT      = 64
) (
    input logic                          clock,
    input logic                          reset,
    pipeline_hazard_controller_if.slave  hz
);

    typedef enum logic [1:0] {RUN, STALL, MEM_WAIT} stateT;

    localparam logic [1:0] BUBBLE_RELOAD = 2'(LOAD_USE_BUBBLES - 1);
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    stateT      state, stateNext;
    stateT      returnState, returnStateNext;
    stateT      effState;
    logic [1:0] bubbleCnt, bubbleCntNext;
    logic [7:0] waitCnt, waitCntNext;
    logic       timeoutErr, timeoutErrNext;
    logic       hazard;
    logic       memWait;

    assign hazard = hz.ex_isLoad && (hz.ex_registerWriteAddress != 5'd0) &&
                    ((hz.id_usesRs && (hz.id_registerRsAddress == hz.ex_registerWriteAddress)) ||
                     (hz.id_usesRt && (hz.id_registerRtAddress == hz.ex_registerWriteAddress)));
    assign memWait = hz.mem_memoryRequest && !hz.mem_memoryReady;

    assign hz.memTimeoutError = timeoutErr;

    // Control state registers; everything returns to idle RUN on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            returnState <= RUN;
            bubbleCnt   <= 2'd0;
            waitCnt     <= 8'd0;
            timeoutErr  <= 1'b0;
        end else begin
            state       <= stateNext;
            returnState <= returnStateNext;
            bubbleCnt   <= bubbleCntNext;
            waitCnt     <= waitCntNext;
            timeoutErr  <= timeoutErrNext;
        end
    end

    // Next-state and enable/flush decode; a wait-exit cycle acts as the saved return state.
    always_comb begin
        stateNext           = state;
        returnStateNext     = returnState;
        bubbleCntNext       = bubbleCnt;
        waitCntNext         = 8'd0;
        timeoutErrNext      = timeoutErr;
        hz.pcEnable         = 1'b1;
        hz.ifIdEnable       = 1'b1;
        hz.idExEnable       = 1'b1;
        hz.exMemEnable      = 1'b1;
        hz.memWbEnable      = 1'b1;
        hz.pcSelectRedirect = 1'b0;
        hz.ifIdFlush        = 1'b0;
        hz.idExFlush        = 1'b0;
        hz.exMemFlush       = 1'b0;
        effState            = (state == MEM_WAIT) ? returnState : state;

        if (memWait) begin
            hz.pcEnable     = 1'b0;
            hz.ifIdEnable   = 1'b0;
            hz.idExEnable   = 1'b0;
            hz.exMemEnable  = 1'b0;
            hz.memWbEnable  = 1'b0;
            stateNext       = MEM_WAIT;
            returnStateNext = effState;
            waitCntNext     = (waitCnt == 8'hFF) ? waitCnt : 8'(waitCnt + 8'd1);
            if (waitCntNext >= TIMEOUT_LIMIT)
                timeoutErrNext = 1'b1;
        end else if (hz.mem_shouldRedirect) begin
            // The ID instruction is flushed, so a concurrent hazard is moot.
            hz.pcSelectRedirect = 1'b1;
            hz.ifIdFlush        = 1'b1;
            hz.idExFlush        = 1'b1;
            hz.exMemFlush       = 1'b1;
            bubbleCntNext       = 2'd0;
            stateNext           = RUN;
        end else if (effState == STALL) begin
            hz.pcEnable   = 1'b0;
            hz.ifIdEnable = 1'b0;
            hz.idExFlush  = 1'b1;
            bubbleCntNext = bubbleCnt - 2'd1;
            stateNext     = (bubbleCnt == 2'd1) ? RUN : STALL;
        end else if (hazard) begin
            hz.pcEnable   = 1'b0;
            hz.ifIdEnable = 1'b0;
            hz.idExFlush  = 1'b1;
            if (LOAD_USE_BUBBLES == 1) begin
                stateNext = RUN;
            end else begin
                bubbleCntNext = BUBBLE_RELOAD;
                stateNext     = STALL;
            end
        end else begin
            stateNext = RUN;
        end

        // While reset is held the pipeline must free-run with no bubbles.
        if (!reset) begin
            hz.pcEnable         = 1'b1;
            hz.ifIdEnable       = 1'b1;
            hz.idExEnable       = 1'b1;
            hz.exMemEnable      = 1'b1;
            hz.memWbEnable      = 1'b1;
            hz.pcSelectRedirect = 1'b0;
            hz.ifIdFlush        = 1'b0;
            hz.idExFlush        = 1'b0;
            hz.exMemFlush       = 1'b0;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] stallCnt;
    logic [31:0] redirCnt;

    // Performance counters: PC-frozen cycles and redirect cycles, free-wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stallCnt <= 32'd0;
            redirCnt <= 32'd0;
        end else begin
            if (!hz.pcEnable)
                stallCnt <= stallCnt + 32'd1;
            if (hz.pcSelectRedirect)
                redirCnt <= redirCnt + 32'd1;
        end
    end

    assign hz.stallCycleCount = stallCnt;
    assign hz.redirectCount   = redirCnt;
`else
    assign hz.stallCycleCount = 32'h0;
    assign hz.redirectCount   = 32'h0;
`endif

endmodule
